instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

- Front-end reader for the combinational instruction memory.
- Owns the program counter and drives the memory `Address` port. The memory returns `Instruction` in the same cycle, and the unit captures it into a 2-entry fetch queue tagged with its PC.
- Delivers fetched words to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump target) from execute; a redirect flushes the queue and restarts fetch at the new PC.

## Interface
- `l`, 16, instruction and address width in bits.
- `ResetPC`, 0, PC value loaded on reset.
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  one clock; reset is synchronous and active-high.
- `Address`  out  l  current PC driven to instruction memory.
- `Instruction`  in  l  memory read data for `Address`, valid in the same cycle.
- `FetchValid`  out  1  head of queue holds a valid instruction.
- `FetchReady`  in  1  decode accepts the head this cycle.
- `FetchInstruction`  out  l  instruction word at the head.
- `FetchPC`  out  l  address the head word was fetched from.
- `Redirect`  in  1  restart fetch at `RedirectPC`.
- `RedirectPC`  in  l  new fetch address.

## Operation
- **State:**
  - PC register.
  - Queue of 2 entries, each {pc, instr}, with head pointer, tail pointer and 2-bit count (0..2).
- **Outputs:**
  - `Address` = PC register; it is not a combinational function of any input.
  - `FetchValid` = (count != 0).
  - `FetchInstruction` and `FetchPC` come from the head entry.
- **Pop:** `FetchValid & FetchReady`; head advances and count decrements.
- **Push (capture):** occurs when `!Redirect` and (count < 2 or pop this cycle).
  - Writes {PC, `Instruction`} at tail.
  - PC <= PC + 1, mod 2^l; word addressing, so 16'hFFFF wraps to 0.
- **No push:** PC holds.
- **Simultaneous push and pop:** count unchanged.
- **Full with pop (count = 2):** push is allowed; queue stays full; throughput is 1 instr/cycle.
- **Redirect (highest priority):**
  - PC <= `RedirectPC`; count <= 0; pointers <= 0; no push that cycle.
  - A pop coinciding with `Redirect` still completes: decode has taken the head, and the rest of the queue is discarded.
- **Stability:** while `FetchValid & !FetchReady`, `FetchInstruction` and `FetchPC` hold stable.
- **Reset:**
  - PC = `ResetPC`, count = 0, pointers = 0.
  - `FetchValid` = 0, `Address` = `ResetPC`.
  - `FetchInstruction` and `FetchPC` = 0.
  - Reset overrides `Redirect`.
  - Reset mid-stream discards all queued entries.
- **No decoding:** the unit does not interpret opcodes; all-zero words are passed through as ordinary instructions.

## Timing
- **First fetch after reset:** the word at `ResetPC` is captured in the first cycle after `Reset` deasserts. `FetchValid` rises in the next cycle (latency 1).
- **Redirect:**
  - Redirect asserted in cycle n → `FetchValid` = 0 in cycle n+1.
  - The word at `RedirectPC` is presented in cycle n+2 (bubble of 1).
- **Back-pressure:** with `FetchReady` held low, the queue fills in 2 cycles and the PC stops advancing. Raising `FetchReady` resumes fetch the same cycle with no bubble.
- **Register boundaries:** all state updates on the rising edge of `Clock`. There is no combinational path from `FetchReady` or `Redirect` to any output.

## Structure
- **Shared package `risc_i16_pkg`:**
  - Instruction width constant.
  - Field positions: opcode [15:13], regA [12:10], regB [9:7], imm10 [9:0], imm7 [6:0].
  - Default reset PC constant.
  - Reused later by decode.
- **Sub-module `fetch_queue`:** 2-entry synchronous FIFO, parameterized on entry width (2*l), with push/pop/flush and valid/full flags.
- **Top level:** the PC register and the push/redirect control.

## Test plan
Program image used by all scenarios: 0:16'h6002, 1:16'h6403, 2:16'hE801, 3:16'h4D04, others 16'h0000.

- **Reset then stream:** hold `Reset` 2 cycles, release, `FetchReady` = 1 → `FetchValid` rises 1 cycle after release. Bench expects (PC, instr) = (0,6002), (1,6403), (2,E801), (3,4D04), (4,0000) on consecutive cycles.
- **Back-pressure:** `FetchReady` = 0 for 5 cycles after the first valid → head stays (0,6002), `Address` freezes at 2, count = 2. Raising `FetchReady` yields 6002, 6403, E801 on consecutive cycles with no bubble.
- **Redirect:** assert `Redirect` with `RedirectPC` = 1 while the head is (2,E801) and `FetchReady` = 1 → E801 is accepted that cycle. Next cycle `FetchValid` = 0; the following cycle shows (1,6403), then (2,E801).
- **Wrap-around:** redirect to 16'hFFFF → outputs (FFFF,0000), then (0,6002), then (1,6403).
- **Reset mid-operation:** assert `Reset` with the queue full and the `Redirect` input asserted (`RedirectPC` = 3) → next cycle `FetchValid` = 0 and `Address` = 0. After release the stream restarts at (0,6002).

Source files
------------

// File: rtl/risc_i16_pkg.sv
// risc_i16_pkg: shared ISA widths, field positions and reset PC for the 16-bit core
package risc_i16_pkg;
    localparam int ILEN = 16;
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 13;
    localparam int REGA_MSB = 12;
    localparam int REGA_LSB = 10;
    localparam int REGB_MSB = 9;
    localparam int REGB_LSB = 7;
    localparam int IMM10_MSB = 9;
    localparam int IMM7_MSB = 6;
    localparam logic [ILEN-1:0] RESET_PC = '0;
    typedef logic [ILEN-1:0] word_t;
    function automatic logic [2:0] opcode_of(word_t w);
        return w[OPCODE_MSB:OPCODE_LSB];
    endfunction
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: memory, decode and redirect signals of the fetch unit
interface instruction_fetch_unit_if #(parameter int L = 16) ();
    logic [L-1:0] Address;
    logic [L-1:0] Instruction;
    logic         FetchValid;
    logic         FetchReady;
    logic [L-1:0] FetchInstruction;
    logic [L-1:0] FetchPC;
    logic         Redirect;
    logic [L-1:0] RedirectPC;
    modport master (
        output Address, FetchValid, FetchInstruction, FetchPC,
        input  Instruction, FetchReady, Redirect, RedirectPC
    );
    modport slave (
        input  Address, FetchValid, FetchInstruction, FetchPC,
        output Instruction, FetchReady, Redirect, RedirectPC
    );
endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// fetch_queue: 2-entry synchronous FIFO with flush, valid and full flags
module fetch_queue #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         full
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         head_q, head_d, tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    // next pointers/count/storage; flush drops everything but keeps storage
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) mem_d[tail_q] = din;
            tail_d  = push ? ~tail_q : tail_q;
            head_d  = pop ? ~head_q : head_q;
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end
    // state registers; storage cleared on reset so the head reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
    assign dout  = mem_q[head_q];
    assign valid = count_q != 2'd0;
    assign full  = count_q == 2'd2;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC register, push/redirect control and fetch queue
module instruction_fetch_unit
    import risc_i16_pkg::*;
#(
    parameter int           l       = ILEN,
    parameter logic [l-1:0] ResetPC = l'(RESET_PC)
) (
    input logic Clock,
    input logic Reset,
    instruction_fetch_unit_if.master bus
);
    logic [l-1:0]   pc_q, pc_d;
    logic [2*l-1:0] head;
    logic           pop, push, valid, full;
    assign pop  = valid & bus.FetchReady;
    assign push = !bus.Redirect & (!full | pop);
    // redirect wins; otherwise the PC advances only when a word is captured
    always_comb begin
        pc_d = bus.Redirect ? bus.RedirectPC : push ? pc_q + l'(1) : pc_q;
    end
    // PC register
    always_ff @(posedge Clock) begin
        if (Reset) pc_q <= ResetPC;
        else pc_q <= pc_d;
    end
    fetch_queue #(.W(2*l)) u_queue (
        .clk   (Clock),
        .rst   (Reset),
        .flush (bus.Redirect),
        .push  (push),
        .pop   (pop),
        .din   ({pc_q, bus.Instruction}),
        .dout  (head),
        .valid (valid),
        .full  (full)
    );
    assign bus.Address          = pc_q;
    assign bus.FetchValid       = valid;
    assign bus.FetchPC          = head[2*l-1:l];
    assign bus.FetchInstruction = head[l-1:0];
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed plan plus random traffic against a queue model
module tb_instruction_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    logic [15:0] m_pc;
    logic [31:0] mq [$];
    instruction_fetch_unit_if bus ();
    instruction_fetch_unit dut (.Clock(clk), .Reset(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [15:0] img(logic [15:0] a);
        case (a)
            16'd0:   return 16'h6002;
            16'd1:   return 16'h6403;
            16'd2:   return 16'hE801;
            16'd3:   return 16'h4D04;
            default: return 16'h0000;
        endcase
    endfunction
    assign bus.Instruction = img(bus.Address);
    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic expect_head(logic [15:0] pc, logic [15:0] ins);
        chk("head_valid", 16'(bus.FetchValid), 16'd1);
        chk("head_pc", bus.FetchPC, pc);
        chk("head_instr", bus.FetchInstruction, ins);
    endtask
    task automatic cyc(logic r, logic rdy, logic rd, logic [15:0] rpc);
        logic [31:0] h;
        rst = r;
        bus.FetchReady = rdy;
        bus.Redirect = rd;
        bus.RedirectPC = rpc;
        #1;
        chk("valid", 16'(bus.FetchValid), 16'(mq.size() != 0));
        chk("address", bus.Address, m_pc);
        if (mq.size() != 0) begin
            h = mq[0];
            chk("pc", bus.FetchPC, h[31:16]);
            chk("instr", bus.FetchInstruction, h[15:0]);
        end
        if (r) begin
            mq.delete();
            m_pc = 16'd0;
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (rd) begin
                mq.delete();
                m_pc = rpc;
            end else if (mq.size() < 2) begin
                mq.push_back({m_pc, img(m_pc)});
                m_pc = m_pc + 16'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [15:0] rpc;
        rst = 1'b1;
        bus.FetchReady = 1'b0;
        bus.Redirect = 1'b0;
        bus.RedirectPC = 16'd0;
        m_pc = 16'd0;
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0);
        chk("rst_valid", 16'(bus.FetchValid), 16'd0);
        chk("rst_addr", bus.Address, 16'd0);
        chk("rst_instr", bus.FetchInstruction, 16'd0);
        chk("rst_pc", bus.FetchPC, 16'd0);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            expect_head(16'(i), img(16'(i)));
            cyc(0, 1, 0, 0);
        end
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        expect_head(16'd0, 16'h6002);
        chk("bp_addr", bus.Address, 16'd2);
        cyc(0, 1, 0, 0);
        expect_head(16'd1, 16'h6403);
        cyc(0, 1, 0, 0);
        expect_head(16'd2, 16'hE801);
        cyc(0, 1, 1, 16'd1);
        chk("redir_bubble", 16'(bus.FetchValid), 16'd0);
        cyc(0, 1, 0, 0);
        expect_head(16'd1, 16'h6403);
        cyc(0, 1, 0, 0);
        expect_head(16'd2, 16'hE801);
        cyc(0, 1, 1, 16'hFFFF);
        chk("wrap_bubble", 16'(bus.FetchValid), 16'd0);
        cyc(0, 1, 0, 0);
        expect_head(16'hFFFF, 16'h0000);
        cyc(0, 1, 0, 0);
        expect_head(16'd0, 16'h6002);
        cyc(0, 1, 0, 0);
        expect_head(16'd1, 16'h6403);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        cyc(1, 0, 1, 16'd3);
        chk("mid_rst_valid", 16'(bus.FetchValid), 16'd0);
        chk("mid_rst_addr", bus.Address, 16'd0);
        cyc(0, 1, 0, 0);
        expect_head(16'd0, 16'h6002);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: rpc = 16'hFFFF;
                1: rpc = 16'hFFFE;
                2: rpc = 16'($urandom_range(0, 5));
                default: rpc = 16'($urandom);
            endcase
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) == 0, rpc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
